// File: rtl/pulse_sync_sched.sv
// Round-robin scheduler sharing one pulse_sync lane between NUM_REQ source-domain
// requesters; issues spaced single-cycle pulses with a stable id_out sideband.
module pulse_sync_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4,
  parameter int MIN_GAP = 6,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_in,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req_pulse,
  input  logic [NUM_REQ-1:0] req_en,
  input  logic               ovf_clr,
  output logic               din_out,
  output logic [ID_W-1:0]    id_out,
  output logic [NUM_REQ-1:0] pending,
  output logic [NUM_REQ-1:0] pend_ovf,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ISSUE, GAP} state_t;

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_nxt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   cnt [NUM_REQ];
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] elig;
  logic               grant_any;
  logic               grant_do;
  logic               gap_last;

  always_comb begin
    elig    = '0;
    pending = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pending[i] = (cnt[i] != '0);
      elig[i]    = (cnt[i] != '0) && req_en[i];
    end
  end

  // Walk from farthest to nearest so the candidate closest after rr_ptr wins.
  always_comb begin
    logic [ID_W-1:0] cand;
    cand      = '0;
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (elig[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign gap_last = (gap_cnt == GAP_W'(MIN_GAP - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    grant_do  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          grant_do  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ISSUE;
      ISSUE: state_nxt = GAP;
      GAP: begin
        if (gap_last) begin
          if (grant_any) begin
            grant_do  = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      gap_cnt <= '0;
      rr_ptr  <= ID_W'(NUM_REQ - 1);
      id_out  <= '0;
      din_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      din_out <= (state_nxt == ISSUE);
      if (grant_do) begin
        rr_ptr <= grant_idx;
        id_out <= grant_idx;
      end
    end
  end

  // A pulse arriving at saturation is lost; a grant in the same cycle absorbs it instead.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      pend_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_pulse[i] && !(grant_do && grant_idx == ID_W'(i))) begin
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
        end else if (!req_pulse[i] && grant_do && grant_idx == ID_W'(i)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
        if (req_pulse[i] && !(grant_do && grant_idx == ID_W'(i)) && cnt[i] == CNT_MAX)
          pend_ovf[i] <= 1'b1;
        else if (ovf_clr)
          pend_ovf[i] <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pulse_sync_sched.md
Name: pulse_sync_sched

Overview:
- Shares one pulse_sync lane between NUM_REQ requesters in the source clock domain.
- Counts each requester's event pulses and issues them one at a time onto the lane's din, round-robin.
- Holds a quasi-static id_out sideband stable around every issued pulse so the destination can tag it.
- Enforces a minimum spacing between issued pulses, which the lane needs: pulses must be at least 1.5 destination clock periods apart.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- CNT_W, 4, width of each per-requester pending counter; counters saturate at 2^CNT_W-1.
- MIN_GAP, 6, number of GAP cycles after each issued pulse (>=1). Integrator sizes it to cover 1.5 destination periods plus destination id sampling.
- ID_W, $clog2(NUM_REQ), derived localparam, width of id_out.

Ports:
- clk_in  in  1  source-domain clock.
- resetn  in  1  asynchronous active-low reset.
- req_pulse  in  NUM_REQ  one bit per requester; each high cycle is one event.
- req_en  in  NUM_REQ  per-requester arbitration enable. A disabled requester still accumulates events.
- ovf_clr  in  1  clears all sticky overflow flags.
- din_out  out  1  single-cycle pulse to the lane's din.
- id_out  out  ID_W  index of the requester whose pulse is in flight.
- pending  out  NUM_REQ  bit i high when counter i is non-zero.
- pend_ovf  out  NUM_REQ  sticky flag: an event was lost to saturation.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - Counters, pend_ovf, din_out, id_out and busy go to 0.
  - State goes to IDLE.
  - RR pointer goes to NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-pulse drops din_out at once and discards all pending events. The lane is reset by the same resetn.
- Counter i, evaluated each cycle:
  - +1 on req_pulse[i]; -1 when granted.
  - Increment and grant in the same cycle: counter unchanged.
  - Increment at max without a grant: counter holds max and pend_ovf[i] sets.
  - pend_ovf[i] clears on ovf_clr. A set in the same cycle as ovf_clr wins.
- Eligible means counter non-zero and req_en[i]=1.
- Grant is round-robin. Search starts at pointer+1 and wraps. The pointer updates to the granted index.
- FSM states:
  - IDLE: when any requester is eligible, grant it, decrement its counter, load id_out and go to SETUP.
  - SETUP: one cycle. id_out is already stable; din_out=0. Go to ISSUE.
  - ISSUE: one cycle with din_out=1 (registered output, high only in this state). Go to GAP.
  - GAP: exactly MIN_GAP cycles with din_out=0 and id_out held.
    - In the last GAP cycle, if any requester is eligible, grant it and go directly to SETUP.
    - Otherwise go to IDLE.
- id_out changes only on the edge that enters SETUP. It is stable from SETUP through the end of the following GAP, and it keeps its value while IDLE.
- Latency: req_pulse high in cycle 0 with the block idle and no other pending events gives counter=1 in cycle 1, SETUP in cycle 2 and din_out=1 in cycle 3.
- Throughput: consecutive din_out pulses are exactly MIN_GAP+2 cycles apart under continuous demand, and never closer.
- req_en deassertion:
  - Takes effect at the next grant decision.
  - A grant already made (SETUP/ISSUE/GAP in progress) always completes.
- No eligible requesters while some counters are non-zero: the block stays in IDLE and pending still reflects the counts.

Test Plan:
- Single event: reset, then req_pulse[2] high for 1 cycle at cycle 0. Required: din_out high in cycle 3 only, id_out=2 from cycle 2, pending[2] cleared in cycle 2, busy low again after 6 GAP cycles.
- Round-robin under load: all 4 requesters pulse once in the same cycle. Required: ids issued in order 0,1,2,3; din_out pulses 8 cycles apart (MIN_GAP=6); id_out stable from 1 cycle before each pulse until the next SETUP.
- Saturation: 17 back-to-back pulses on req 1 with req_en[1]=0. Required: counter=15, pend_ovf[1]=1, no din_out. Then set req_en[1]=1. Required: exactly 15 pulses with id_out=1.
- Clear vs set: with counter 3 at max, ovf_clr and req_pulse[3] in the same cycle. Required: pend_ovf[3] remains 1. ovf_clr alone next cycle: required pend_ovf[3]=0.
- Simultaneous increment and grant: req 0 holds count 1 and pulses again in the cycle it is granted. Required: counter stays 1, and a second pulse with id_out=0 is issued 8 cycles after the first.
- Reset mid-operation: assert resetn low during ISSUE. Required: din_out=0 immediately; after release, all outputs are 0, pending=0, and the first grant goes to requester 0.
